// File: rtl/calc_port_arbiter.sv
// Multi-port request front-end for the calculator core: per-port request FIFOs,
// round-robin issue arbitration, per-port tag tracking and response routing.
module calc_port_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CMD_W      = 4,
    parameter int REG_W      = 4,
    parameter int TAG_W      = 2,
    parameter int DATA_W     = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS*CMD_W-1:0]     req_cmd,
    input  logic [NUM_PORTS*REG_W-1:0]     req_d1,
    input  logic [NUM_PORTS*REG_W-1:0]     req_d2,
    input  logic [NUM_PORTS*REG_W-1:0]     req_r1,
    input  logic [NUM_PORTS*TAG_W-1:0]     req_tag,
    input  logic [NUM_PORTS*DATA_W-1:0]    req_data,
    output logic [NUM_PORTS-1:0]           req_ready,
    output logic                           iss_valid,
    input  logic                           iss_ready,
    output logic [$clog2(NUM_PORTS)-1:0]   iss_port,
    output logic [CMD_W-1:0]               iss_cmd,
    output logic [REG_W-1:0]               iss_d1,
    output logic [REG_W-1:0]               iss_d2,
    output logic [REG_W-1:0]               iss_r1,
    output logic [TAG_W-1:0]               iss_tag,
    output logic [DATA_W-1:0]              iss_data,
    input  logic                           rsp_valid,
    input  logic [$clog2(NUM_PORTS)-1:0]   rsp_port,
    input  logic [1:0]                     rsp_resp,
    input  logic [TAG_W-1:0]               rsp_tag,
    input  logic [DATA_W-1:0]              rsp_data,
    output logic [NUM_PORTS*2-1:0]         out_resp,
    output logic [NUM_PORTS*TAG_W-1:0]     out_tag,
    output logic [NUM_PORTS*DATA_W-1:0]    out_data,
    output logic                           err_unexpected
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NT = 2 ** TAG_W;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [REG_W-1:0]  d1;
        logic [REG_W-1:0]  d2;
        logic [REG_W-1:0]  r1;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t                      req_entry  [NUM_PORTS];
    entry_t                      head_entry [NUM_PORTS];
    entry_t                      iss_entry;
    logic [NUM_PORTS-1:0]        fifo_empty;
    logic [NUM_PORTS-1:0]        fifo_full;
    logic [NUM_PORTS-1:0]        req_act;
    logic [NUM_PORTS-1:0]        collide;
    logic [NUM_PORTS-1:0]        push;
    logic [NUM_PORTS-1:0]        pop;
    logic [NUM_PORTS-1:0]        err_pend;
    logic [NUM_PORTS-1:0]        rsp_hit;
    logic [TAG_W-1:0]            req_tag_p  [NUM_PORTS];

    logic [NUM_PORTS-1:0][NT-1:0] outst_reg;
    logic [NUM_PORTS-1:0][NT-1:0] outst_next;
    logic [NUM_PORTS-1:0][NT-1:0] outst_eff;
    logic [NUM_PORTS-1:0][NT-1:0] clr_mask;
    logic [NUM_PORTS-1:0][NT-1:0] set_mask;

    logic [PW-1:0] rr_ptr_reg;
    logic [PW-1:0] lock_port_reg;
    logic          lock_reg;
    logic [PW-1:0] search_port;
    logic          search_found;
    logic [PW-1:0] gnt;
    logic          handshake;
    logic          err_unexpected_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [AW:0]       wr_ptr_reg;
            logic [AW:0]       rd_ptr_reg;
            entry_t            mem [FIFO_DEPTH];
            logic              err_pend_reg;
            logic [TAG_W-1:0]  err_tag_reg;
            logic [1:0]        out_resp_reg;
            logic [TAG_W-1:0]  out_tag_reg;
            logic [DATA_W-1:0] out_data_reg;

            assign req_entry[gi] = {req_cmd[gi*CMD_W +: CMD_W],
                                    req_d1[gi*REG_W +: REG_W],
                                    req_d2[gi*REG_W +: REG_W],
                                    req_r1[gi*REG_W +: REG_W],
                                    req_tag[gi*TAG_W +: TAG_W],
                                    req_data[gi*DATA_W +: DATA_W]};
            assign req_tag_p[gi] = req_tag[gi*TAG_W +: TAG_W];

            assign fifo_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
            assign fifo_full[gi]  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
            assign err_pend[gi]   = err_pend_reg;
            assign req_ready[gi]  = !fifo_full[gi] && !err_pend_reg;

            // Collision is judged after this cycle's response clear is applied.
            assign req_act[gi] = (req_cmd[gi*CMD_W +: CMD_W] != '0) && req_ready[gi];
            assign collide[gi] = req_act[gi] && outst_eff[gi][req_tag_p[gi]];
            assign push[gi]    = req_act[gi] && !collide[gi];
            assign pop[gi]     = handshake && (gnt == PW'(gi));

            assign rsp_hit[gi]    = rsp_valid && (rsp_port == PW'(gi)) && outst_reg[gi][rsp_tag];
            assign clr_mask[gi]   = rsp_hit[gi] ? (NT'(1) << rsp_tag) : '0;
            assign set_mask[gi]   = push[gi] ? (NT'(1) << req_tag_p[gi]) : '0;
            assign outst_eff[gi]  = outst_reg[gi] & ~clr_mask[gi];
            assign outst_next[gi] = outst_eff[gi] | set_mask[gi];

            assign head_entry[gi] = mem[rd_ptr_reg[AW-1:0]];

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg[AW-1:0]] <= req_entry[gi];
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end

            // A core response wins the output slot; a pending error waits a cycle.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    err_pend_reg <= 1'b0;
                    err_tag_reg  <= '0;
                    out_resp_reg <= '0;
                    out_tag_reg  <= '0;
                    out_data_reg <= '0;
                end else begin
                    if (rsp_hit[gi]) begin
                        out_resp_reg <= rsp_resp;
                        out_tag_reg  <= rsp_tag;
                        out_data_reg <= rsp_data;
                    end else if (err_pend_reg) begin
                        out_resp_reg <= 2'b10;
                        out_tag_reg  <= err_tag_reg;
                        out_data_reg <= '0;
                    end else begin
                        out_resp_reg <= 2'b00;
                    end

                    if (collide[gi]) begin
                        err_pend_reg <= 1'b1;
                        err_tag_reg  <= req_tag_p[gi];
                    end else if (err_pend_reg && !rsp_hit[gi]) begin
                        err_pend_reg <= 1'b0;
                    end
                end
            end

            assign out_resp[gi*2 +: 2]          = out_resp_reg;
            assign out_tag[gi*TAG_W +: TAG_W]   = out_tag_reg;
            assign out_data[gi*DATA_W +: DATA_W] = out_data_reg;
        end
    endgenerate

    // Round-robin search: first non-empty port after the last granted one.
    always_comb begin
        search_found = 1'b0;
        search_port  = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            int idx;
            idx = int'(rr_ptr_reg) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!search_found && !fifo_empty[idx]) begin
                search_found = 1'b1;
                search_port  = PW'(idx);
            end
        end
    end

    assign iss_valid = !(&fifo_empty);
    assign gnt       = lock_reg ? lock_port_reg : search_port;
    assign handshake = iss_valid && iss_ready;
    assign iss_entry = iss_valid ? head_entry[gnt] : '0;

    assign iss_port = iss_valid ? gnt : '0;
    assign iss_cmd  = iss_entry.cmd;
    assign iss_d1   = iss_entry.d1;
    assign iss_d2   = iss_entry.d2;
    assign iss_r1   = iss_entry.r1;
    assign iss_tag  = iss_entry.tag;
    assign iss_data = iss_entry.data;

    // A stalled grant is pinned so newly filled higher-priority ports cannot steal it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg    <= PW'(NUM_PORTS - 1);
            lock_reg      <= 1'b0;
            lock_port_reg <= '0;
        end else begin
            lock_reg      <= iss_valid && !iss_ready;
            lock_port_reg <= gnt;
            if (handshake) rr_ptr_reg <= gnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outst_reg          <= '0;
            err_unexpected_reg <= 1'b0;
        end else begin
            outst_reg <= outst_next;
            if (rsp_valid && !(|rsp_hit)) err_unexpected_reg <= 1'b1;
        end
    end

    assign err_unexpected = err_unexpected_reg;

endmodule

// File: tb/tb_calc_port_arbiter.sv
// Directed bench for calc_port_arbiter: issue order, backpressure, tag
// collisions, response routing and reset behaviour.
module tb_calc_port_arbiter;

    localparam int NP = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*4-1:0]   req_cmd, req_d1, req_d2, req_r1;
    logic [NP*2-1:0]   req_tag;
    logic [NP*32-1:0]  req_data;
    logic [NP-1:0]     req_ready;
    logic              iss_valid, iss_ready;
    logic [1:0]        iss_port;
    logic [3:0]        iss_cmd, iss_d1, iss_d2, iss_r1;
    logic [1:0]        iss_tag;
    logic [31:0]       iss_data;
    logic              rsp_valid;
    logic [1:0]        rsp_port, rsp_resp, rsp_tag;
    logic [31:0]       rsp_data;
    logic [NP*2-1:0]   out_resp;
    logic [NP*2-1:0]   out_tag;
    logic [NP*32-1:0]  out_data;
    logic              err_unexpected;

    int n_cmp = 0;
    int n_mis = 0;

    calc_port_arbiter dut (
        .clk(clk), .reset(reset),
        .req_cmd(req_cmd), .req_d1(req_d1), .req_d2(req_d2), .req_r1(req_r1),
        .req_tag(req_tag), .req_data(req_data), .req_ready(req_ready),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_port(iss_port),
        .iss_cmd(iss_cmd), .iss_d1(iss_d1), .iss_d2(iss_d2), .iss_r1(iss_r1),
        .iss_tag(iss_tag), .iss_data(iss_data),
        .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_resp(rsp_resp),
        .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .out_resp(out_resp), .out_tag(out_tag), .out_data(out_data),
        .err_unexpected(err_unexpected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int p, input logic [1:0] tag, input logic [31:0] data);
        req_cmd[p*4 +: 4]   = 4'h1;
        req_d1[p*4 +: 4]    = 4'h1;
        req_d2[p*4 +: 4]    = 4'h2;
        req_r1[p*4 +: 4]    = 4'h3;
        req_tag[p*2 +: 2]   = tag;
        req_data[p*32 +: 32] = data;
    endtask

    task automatic clr_reqs();
        req_cmd = '0; req_d1 = '0; req_d2 = '0; req_r1 = '0;
        req_tag = '0; req_data = '0;
    endtask

    task automatic send_rsp(input logic [1:0] port, input logic [1:0] resp,
                            input logic [1:0] tag, input logic [31:0] data);
        rsp_valid = 1'b1; rsp_port = port; rsp_resp = resp;
        rsp_tag = tag; rsp_data = data;
    endtask

    task automatic clr_rsp();
        rsp_valid = 1'b0; rsp_port = '0; rsp_resp = '0; rsp_tag = '0; rsp_data = '0;
    endtask

    task automatic do_reset();
        clr_reqs();
        clr_rsp();
        iss_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        clr_reqs();
        clr_rsp();
        iss_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'hF);
        chk("rst_iss_valid", 64'(iss_valid), 64'h0);
        chk("rst_iss_data", 64'(iss_data), 64'h0);
        chk("rst_out_resp", 64'(out_resp), 64'h0);
        chk("rst_err_unexp", 64'(err_unexpected), 64'h0);
        reset = 1'b1;

        // Single request on port 2, then its core response.
        set_req(2, 2'd1, 32'd5);
        iss_ready = 1'b1;
        step();
        clr_reqs();
        chk("t1_iss_valid", 64'(iss_valid), 64'h1);
        chk("t1_iss_port", 64'(iss_port), 64'h2);
        chk("t1_iss_tag", 64'(iss_tag), 64'h1);
        chk("t1_iss_data", 64'(iss_data), 64'h5);
        chk("t1_iss_cmd", 64'(iss_cmd), 64'h1);
        chk("t1_iss_d2", 64'(iss_d2), 64'h2);
        step();
        chk("t1_iss_idle", 64'(iss_valid), 64'h0);
        send_rsp(2'd2, 2'd1, 2'd1, 32'd9);
        step();
        clr_rsp();
        chk("t1_out_resp2", 64'(out_resp[5:4]), 64'h1);
        chk("t1_out_data2", 64'(out_data[95:64]), 64'h9);
        chk("t1_out_tag2", 64'(out_tag[5:4]), 64'h1);
        chk("t1_err_unexp", 64'(err_unexpected), 64'h0);
        step();
        chk("t1_resp_idle", 64'(out_resp), 64'h0);
        chk("t1_data_hold", 64'(out_data[95:64]), 64'h9);

        // All ports together: round-robin from port 0 after reset.
        do_reset();
        iss_ready = 1'b1;
        for (int p = 0; p < NP; p++) set_req(p, 2'd0, 32'h10 + 32'(p));
        step();
        clr_reqs();
        for (int p = 0; p < NP; p++) begin
            chk("t2_valid", 64'(iss_valid), 64'h1);
            chk("t2_port", 64'(iss_port), 64'(p));
            chk("t2_data", 64'(iss_data), 64'h10 + 64'(p));
            step();
        end
        chk("t2_drained", 64'(iss_valid), 64'h0);
        set_req(0, 2'd1, 32'h18);
        step();
        clr_reqs();
        chk("t2_round2_port", 64'(iss_port), 64'h0);
        chk("t2_round2_data", 64'(iss_data), 64'h18);
        step();
        chk("t2_round2_idle", 64'(iss_valid), 64'h0);

        // Backpressure: fill port 1, fifth request is ignored, grant stays stable.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("t3_ready_pre", 64'(req_ready[1]), 64'h1);
            set_req(1, 2'(i), 32'h20 + 32'(i));
            step();
            chk("t3_stall_tag", 64'(iss_tag), 64'h0);
            chk("t3_stall_port", 64'(iss_port), 64'h1);
        end
        chk("t3_full_ready", 64'(req_ready[1]), 64'h0);
        set_req(1, 2'd0, 32'h99);
        step();
        clr_reqs();
        chk("t3_still_full", 64'(req_ready[1]), 64'h0);
        chk("t3_stable_data", 64'(iss_data), 64'h20);
        iss_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain_valid", 64'(iss_valid), 64'h1);
            chk("t3_drain_tag", 64'(iss_tag), 64'(i));
            chk("t3_drain_data", 64'(iss_data), 64'h20 + 64'(i));
            step();
        end
        chk("t3_empty", 64'(iss_valid), 64'h0);
        chk("t3_no_err", 64'(out_resp), 64'h0);
        chk("t3_ready_back", 64'(req_ready[1]), 64'h1);

        // Duplicate tag on port 3 yields an error response and one issue only.
        do_reset();
        set_req(3, 2'd2, 32'h30);
        step();
        set_req(3, 2'd2, 32'h31);
        step();
        clr_reqs();
        chk("t4_ready_low", 64'(req_ready[3]), 64'h0);
        chk("t4_no_resp_yet", 64'(out_resp), 64'h0);
        step();
        chk("t4_err_resp", 64'(out_resp[7:6]), 64'h2);
        chk("t4_err_tag", 64'(out_tag[7:6]), 64'h2);
        chk("t4_err_data", 64'(out_data[127:96]), 64'h0);
        chk("t4_ready_back", 64'(req_ready[3]), 64'h1);
        chk("t4_iss_data", 64'(iss_data), 64'h30);
        iss_ready = 1'b1;
        step();
        chk("t4_one_issue", 64'(iss_valid), 64'h0);
        chk("t4_resp_idle", 64'(out_resp[7:6]), 64'h0);

        // Core response and pending error on port 0 in the same cycle.
        do_reset();
        iss_ready = 1'b1;
        set_req(0, 2'd1, 32'h40);
        step();
        clr_reqs();
        chk("t5_iss_port", 64'(iss_port), 64'h0);
        step();
        set_req(0, 2'd1, 32'h41);
        step();
        clr_reqs();
        send_rsp(2'd0, 2'd1, 2'd1, 32'h77);
        step();
        clr_rsp();
        chk("t5_core_resp", 64'(out_resp[1:0]), 64'h1);
        chk("t5_core_data", 64'(out_data[31:0]), 64'h77);
        step();
        chk("t5_err_resp", 64'(out_resp[1:0]), 64'h2);
        chk("t5_err_tag", 64'(out_tag[1:0]), 64'h1);
        chk("t5_err_data", 64'(out_data[31:0]), 64'h0);
        step();
        chk("t5_idle", 64'(out_resp[1:0]), 64'h0);

        // Response for a tag never issued.
        send_rsp(2'd1, 2'd1, 2'd3, 32'h55);
        step();
        clr_rsp();
        chk("t6_err_unexp", 64'(err_unexpected), 64'h1);
        chk("t6_resp1_idle", 64'(out_resp[3:2]), 64'h0);
        chk("t6_data1_hold", 64'(out_data[63:32]), 64'h0);

        // Asynchronous reset in the middle of queued traffic.
        iss_ready = 1'b0;
        set_req(0, 2'd0, 32'h60);
        set_req(2, 2'd0, 32'h62);
        step();
        clr_reqs();
        chk("t7_busy", 64'(iss_valid), 64'h1);
        reset = 1'b0;
        #1;
        chk("t7_rst_ready", 64'(req_ready), 64'hF);
        chk("t7_rst_valid", 64'(iss_valid), 64'h0);
        chk("t7_rst_unexp", 64'(err_unexpected), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        send_rsp(2'd2, 2'd1, 2'd0, 32'h88);
        step();
        clr_rsp();
        chk("t7_late_unexp", 64'(err_unexpected), 64'h1);
        chk("t7_late_drop", 64'(out_resp), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
